// File: rtl/tx_mac_arbiter.sv
// -----------------------------------------------------------------------------
// tx_mac_arbiter
//
// Two-requester byte-stream arbiter in front of a MAC transmit port. One
// requester at a time owns the MAC for a whole frame. The owner's stream is
// passed through combinationally. After each frame the block holds off all
// requesters for GAP_CYCLES idle cycles. Ties in IDLE are broken round robin.
//
// Parameters
//   GAP_CYCLES   idle cycles inserted after each frame (0..255)
//
// Ports
//   tx_mac_clk                 only clock, rising edge
//   reset                      synchronous, active-high
//   reqN_valid/data/last/err   requester N byte stream (N = 0, 1)
//   reqN_ready                 requester N byte accepted (ready & valid)
//   tx_mac_valid/data/last/error  MAC TX stream
//   tx_mac_ready               MAC accepts the byte this cycle
//   tx_collision               MAC collision indication
//   grant                      one-hot owner: 01 = req0, 10 = req1, 00 = none
//   frame_cnt0/1               saturating count of completed frames per requester
//   coll_cnt                   saturating count of collision cycles while granted
// -----------------------------------------------------------------------------
module tx_mac_arbiter #(
  parameter int GAP_CYCLES = 12
) (
  input  logic        tx_mac_clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  input  logic        req0_err,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  input  logic        req1_err,
  output logic        req1_ready,
  output logic        tx_mac_valid,
  output logic [7:0]  tx_mac_data,
  output logic        tx_mac_last,
  output logic        tx_mac_error,
  input  logic        tx_mac_ready,
  input  logic        tx_collision,
  output logic [1:0]  grant,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [15:0] coll_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Value loaded into the gap counter on the last byte; it counts down to 0
  // inclusive, so the FSM spends exactly GAP_CYCLES cycles in GAP.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic       last_grant;   // 0: req0 was granted last, 1: req1 was
  logic [7:0] gap_cnt;

  // Handshakes are qualified by state, so they can only occur while granted.
  logic hs0;
  logic hs1;
  logic hs0_last;
  logic hs1_last;
  logic granted;

  assign hs0      = (state == GRANT0) && req0_valid && tx_mac_ready;
  assign hs1      = (state == GRANT1) && req1_valid && tx_mac_ready;
  assign hs0_last = hs0 && req0_last;
  assign hs1_last = hs1 && req1_last;
  assign granted  = (state == GRANT0) || (state == GRANT1);

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge tx_mac_clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gap_cnt    <= 8'd0;
      frame_cnt0 <= 16'd0;
      frame_cnt1 <= 16'd0;
      coll_cnt   <= 16'd0;
    end else begin
      state <= state_nx;

      if (state == IDLE && state_nx == GRANT0) begin
        last_grant <= 1'b0;
      end else if (state == IDLE && state_nx == GRANT1) begin
        last_grant <= 1'b1;
      end

      if (hs0_last || hs1_last) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      if (hs0_last && frame_cnt0 != 16'hFFFF) begin
        frame_cnt0 <= frame_cnt0 + 16'd1;
      end
      if (hs1_last && frame_cnt1 != 16'hFFFF) begin
        frame_cnt1 <= frame_cnt1 + 16'd1;
      end

      if (granted && tx_collision && coll_cnt != 16'hFFFF) begin
        coll_cnt <= coll_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path assigns state_nx and no
    // latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE: begin
        // On a tie, last_grant = 1 means req1 went last, so req0 wins.
        if (req0_valid && (!req1_valid || last_grant)) begin
          state_nx = GRANT0;
        end else if (req1_valid) begin
          state_nx = GRANT1;
        end
      end
      GRANT0: begin
        if (hs0_last) begin
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GRANT1: begin
        if (hs1_last) begin
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    tx_mac_valid = 1'b0;
    tx_mac_data  = 8'h00;
    tx_mac_last  = 1'b0;
    tx_mac_error = 1'b0;
    grant        = 2'b00;
    // Outputs are forced idle while reset is high, even before the reset edge
    // has pulled the state back to IDLE.
    if (!reset) begin
      unique case (state)
        GRANT0: begin
          req0_ready   = tx_mac_ready;
          tx_mac_valid = req0_valid;
          tx_mac_data  = req0_data;
          tx_mac_last  = req0_last;
          tx_mac_error = req0_err;
          grant        = 2'b01;
        end
        GRANT1: begin
          req1_ready   = tx_mac_ready;
          tx_mac_valid = req1_valid;
          tx_mac_data  = req1_data;
          tx_mac_last  = req1_last;
          tx_mac_error = req1_err;
          grant        = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_mac_arbiter
//
// Directed bench for tx_mac_arbiter. Two instances: dut (GAP_CYCLES = 12) and
// dut_ng (GAP_CYCLES = 0). They share requester/MAC inputs but have separate
// resets; whichever instance is not under test is held in reset. Expected
// bytes are queued per requester when driven and popped when the MAC side of
// dut hands them off.
// -----------------------------------------------------------------------------
module tb_tx_mac_arbiter;

  logic        tx_mac_clk = 1'b0;
  logic        reset;
  logic        reset_ng;
  logic        req0_valid, req0_last, req0_err;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_last, req1_err;
  logic [7:0]  req1_data;
  logic        tx_mac_ready;
  logic        tx_collision;

  logic        req0_ready, req1_ready;
  logic        tx_mac_valid, tx_mac_last, tx_mac_error;
  logic [7:0]  tx_mac_data;
  logic [1:0]  grant;
  logic [15:0] frame_cnt0, frame_cnt1, coll_cnt;

  logic        req0_ready_ng, req1_ready_ng;
  logic        tx_mac_valid_ng, tx_mac_last_ng, tx_mac_error_ng;
  logic [7:0]  tx_mac_data_ng;
  logic [1:0]  grant_ng;
  logic [15:0] frame_cnt0_ng, frame_cnt1_ng, coll_cnt_ng;

  int checks = 0;
  int errors = 0;

  logic [9:0]  q0[$];      // expected {data, last, err} for req0
  logic [9:0]  q1[$];      // expected {data, last, err} for req1
  logic [1:0]  glog[$];    // grant seen on each last-byte handoff
  logic        mirror_en = 1'b0;
  logic [10:0] exp_b;

  tx_mac_arbiter #(.GAP_CYCLES(12)) dut (
    .tx_mac_clk  (tx_mac_clk),   .reset       (reset),
    .req0_valid  (req0_valid),   .req0_data   (req0_data),
    .req0_last   (req0_last),    .req0_err    (req0_err),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),   .req1_data   (req1_data),
    .req1_last   (req1_last),    .req1_err    (req1_err),
    .req1_ready  (req1_ready),
    .tx_mac_valid(tx_mac_valid), .tx_mac_data (tx_mac_data),
    .tx_mac_last (tx_mac_last),  .tx_mac_error(tx_mac_error),
    .tx_mac_ready(tx_mac_ready), .tx_collision(tx_collision),
    .grant       (grant),
    .frame_cnt0  (frame_cnt0),   .frame_cnt1  (frame_cnt1),
    .coll_cnt    (coll_cnt)
  );

  tx_mac_arbiter #(.GAP_CYCLES(0)) dut_ng (
    .tx_mac_clk  (tx_mac_clk),      .reset       (reset_ng),
    .req0_valid  (req0_valid),      .req0_data   (req0_data),
    .req0_last   (req0_last),       .req0_err    (req0_err),
    .req0_ready  (req0_ready_ng),
    .req1_valid  (req1_valid),      .req1_data   (req1_data),
    .req1_last   (req1_last),       .req1_err    (req1_err),
    .req1_ready  (req1_ready_ng),
    .tx_mac_valid(tx_mac_valid_ng), .tx_mac_data (tx_mac_data_ng),
    .tx_mac_last (tx_mac_last_ng),  .tx_mac_error(tx_mac_error_ng),
    .tx_mac_ready(tx_mac_ready),    .tx_collision(tx_collision),
    .grant       (grant_ng),
    .frame_cnt0  (frame_cnt0_ng),   .frame_cnt1  (frame_cnt1_ng),
    .coll_cnt    (coll_cnt_ng)
  );

  always #5 tx_mac_clk = ~tx_mac_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte handed to the MAC must be the next queued byte of
  // the requester currently shown on grant.
  always @(negedge tx_mac_clk) begin
    if (tx_mac_valid && tx_mac_ready) begin
      if (grant == 2'b10) exp_b = (q1.size() > 0) ? {1'b0, q1.pop_front()} : 11'h400;
      else                exp_b = (q0.size() > 0) ? {1'b0, q0.pop_front()} : 11'h400;
      check("sb_byte", {21'd0, 1'b0, tx_mac_data, tx_mac_last, tx_mac_error}, {21'd0, exp_b});
      if (tx_mac_last) glog.push_back(grant);
    end
    if (mirror_en) begin
      check("r0_ready_low", {31'd0, req0_ready}, 32'd0);
      if (grant == 2'b10) check("r1_ready_mirror", {31'd0, req1_ready}, {31'd0, tx_mac_ready});
    end
  end

  task automatic idle_port(input int p);
    if (p == 0) begin req0_valid = 0; req0_data = 8'h00; req0_last = 0; req0_err = 0; end
    else        begin req1_valid = 0; req1_data = 8'h00; req1_last = 0; req1_err = 0; end
  endtask

  // Present one byte, queue it as expected, and wait (bounded) until accepted.
  // Returns 1 time unit after the accepting edge.
  task automatic drive_byte(input int p, input logic [7:0] d, input logic l, input logic e);
    if (p == 0) begin
      req0_valid = 1; req0_data = d; req0_last = l; req0_err = e; q0.push_back({d, l, e});
    end else begin
      req1_valid = 1; req1_data = d; req1_last = l; req1_err = e; q1.push_back({d, l, e});
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge tx_mac_clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        @(posedge tx_mac_clk);
        #1;
        return;
      end
    end
    check("hs_timeout", {31'd0, (p == 0) ? req0_ready : req1_ready}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge tx_mac_clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic rdy_seen;
    reset = 1; reset_ng = 1;
    idle_port(0); idle_port(1);
    tx_collision = 0;

    // ---- Reset values, outputs idle while reset is high even with a request
    req0_valid = 1; req0_data = 8'hEE; tx_mac_ready = 1;
    repeat (2) @(posedge tx_mac_clk);
    @(negedge tx_mac_clk);
    check("rst_grant",    {30'd0, grant}, 32'd0);
    check("rst_valid",    {31'd0, tx_mac_valid}, 32'd0);
    check("rst_data",     {24'd0, tx_mac_data}, 32'd0);
    check("rst_r0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_cnts",     {frame_cnt0 | frame_cnt1, coll_cnt}, 32'd0);
    idle_port(0);
    @(posedge tx_mac_clk); #1;
    reset = 0;

    // ---- 4-byte req0 frame, one-cycle grant latency, 12-cycle gap
    req0_valid = 1; req0_data = 8'h11; req0_last = 0; req0_err = 0;
    q0.push_back({8'h11, 1'b0, 1'b0});
    @(negedge tx_mac_clk);
    check("lat_idle_grant", {30'd0, grant}, 32'd0);
    check("lat_idle_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge tx_mac_clk);
    check("lat_grant0",     {30'd0, grant}, 32'h1);
    check("lat_mac_valid",  {31'd0, tx_mac_valid}, 32'd1);
    @(posedge tx_mac_clk); #1;
    drive_byte(0, 8'h22, 0, 0);
    drive_byte(0, 8'h33, 0, 1);
    drive_byte(0, 8'h44, 1, 0);
    check("f1_cnt0", {16'd0, frame_cnt0}, 32'd1);
    // Next request is held through 12 GAP cycles plus the IDLE arbitration cycle.
    req0_valid = 1; req0_data = 8'h55; req0_last = 1; req0_err = 0;
    q0.push_back({8'h55, 1'b1, 1'b0});
    n = 0; rdy_seen = 0;
    while (n < 40) begin
      @(negedge tx_mac_clk);
      if (grant == 2'b01) break;
      rdy_seen |= req0_ready;
      n++;
    end
    check("gap_len",       n, 32'd13);
    check("gap_ready_low", {31'd0, rdy_seen}, 32'd0);
    @(posedge tx_mac_clk); #1;
    idle_port(0);
    check("f2_cnt0", {16'd0, frame_cnt0}, 32'd2);
    check("f1_sb_empty", q0.size() + q1.size(), 32'd0);

    // ---- Round robin with both requesters continuously valid
    do_reset();
    glog.delete();
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          drive_byte(0, 8'hA0 + 8'(f * 2), 0, 0);
          drive_byte(0, 8'hA1 + 8'(f * 2), 1, 0);
        end
        idle_port(0);
      end
      begin
        for (int f = 0; f < 2; f++) begin
          drive_byte(1, 8'hB0 + 8'(f * 2), 0, 0);
          drive_byte(1, 8'hB1 + 8'(f * 2), 1, 1);
        end
        idle_port(1);
      end
    join
    check("rr_frames", glog.size(), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      check("rr_order", {30'd0, glog[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
    check("rr_cnt0", {16'd0, frame_cnt0}, 32'd2);
    check("rr_cnt1", {16'd0, frame_cnt1}, 32'd2);

    // ---- Backpressure: tx_mac_ready toggles during a req1 frame
    do_reset();
    mirror_en = 1;
    begin
      logic stop;
      stop = 0;
      tx_mac_ready = 1;
      fork
        begin
          drive_byte(1, 8'hD0, 0, 0);
          drive_byte(1, 8'hD1, 0, 0);
          drive_byte(1, 8'hD2, 0, 1);
          drive_byte(1, 8'hD3, 1, 0);
          stop = 1;
        end
        begin
          while (!stop) begin
            @(posedge tx_mac_clk); #1;
            if (!stop) tx_mac_ready = ~tx_mac_ready;
          end
        end
      join
    end
    idle_port(1);
    mirror_en = 0;
    tx_mac_ready = 1;
    check("bp_sb_empty", q0.size() + q1.size(), 32'd0);
    check("bp_cnt1", {16'd0, frame_cnt1}, 32'd1);

    // ---- Collisions: 2 cycles in IDLE ignored, 3 cycles in GRANT1 counted
    do_reset();
    tx_collision = 1;
    repeat (2) @(posedge tx_mac_clk);
    #1;
    tx_collision = 0;
    check("coll_idle", {16'd0, coll_cnt}, 32'd0);
    tx_mac_ready = 0;
    req1_valid = 1; req1_data = 8'hE0; req1_last = 0; req1_err = 0;
    q1.push_back({8'hE0, 1'b0, 1'b0});
    @(posedge tx_mac_clk); #1;
    tx_collision = 1;
    repeat (3) @(posedge tx_mac_clk);
    #1;
    tx_collision = 0;
    check("coll_grant1", {16'd0, coll_cnt}, 32'd3);
    check("coll_grant_kept", {30'd0, grant}, 32'h2);
    tx_mac_ready = 1;
    @(posedge tx_mac_clk); #1;
    drive_byte(1, 8'hE1, 0, 0);
    drive_byte(1, 8'hE2, 1, 0);
    idle_port(1);
    check("coll_frame_done", {16'd0, frame_cnt1}, 32'd1);
    check("coll_final", {16'd0, coll_cnt}, 32'd3);

    // ---- Reset on the third byte of a req0 frame
    drive_byte(0, 8'hF0, 0, 0);
    drive_byte(0, 8'hF1, 0, 0);
    tx_mac_ready = 0;
    req0_valid = 1; req0_data = 8'hF2; req0_last = 1; req0_err = 0;
    @(negedge tx_mac_clk);
    check("mid_grant0", {30'd0, grant}, 32'h1);
    #1;
    reset = 1;
    tx_mac_ready = 1;
    @(posedge tx_mac_clk); #1;
    idle_port(0);
    reset = 0;
    @(negedge tx_mac_clk);
    check("mid_rst_grant", {30'd0, grant}, 32'd0);
    check("mid_rst_valid", {31'd0, tx_mac_valid}, 32'd0);
    check("mid_rst_cnt0",  {16'd0, frame_cnt0}, 32'd0);
    check("mid_rst_cnt1",  {16'd0, frame_cnt1}, 32'd0);
    check("mid_rst_coll",  {16'd0, coll_cnt}, 32'd0);
    @(posedge tx_mac_clk); #1;
    glog.delete();
    fork
      drive_byte(0, 8'hC0, 1, 0);
      drive_byte(1, 8'hC1, 1, 0);
    join
    idle_port(0); idle_port(1);
    check("tie_frames", glog.size(), 32'd2);
    if (glog.size() == 2) begin
      check("tie_first_req0", {30'd0, glog[0]}, 32'h1);
      check("tie_then_req1",  {30'd0, glog[1]}, 32'h2);
    end
    check("tie_sb_empty", q0.size() + q1.size(), 32'd0);

    // ---- GAP_CYCLES = 0: back-to-back single-byte frames from req0
    reset = 1;
    req0_valid = 1; req0_data = 8'h5A; req0_last = 1; req0_err = 0;
    tx_mac_ready = 1;
    @(posedge tx_mac_clk); #1;
    reset_ng = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge tx_mac_clk);
      check("ng_grant", {30'd0, grant_ng}, (k % 2 == 1) ? 32'h1 : 32'h0);
      check("ng_cnt0",  {16'd0, frame_cnt0_ng}, k / 2);
      if (k % 2 == 1) check("ng_data", {22'd0, tx_mac_data_ng, tx_mac_last_ng, tx_mac_valid_ng}, 32'h16B);
    end
    idle_port(0);
    reset_ng = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_mac_arbiter.md
TX_MAC_ARBITER -- requirements
Module: tx_mac_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 12, setting the idle cycles inserted after each frame; legal range 0..255.
REQ-002 The block SHALL have port tx_mac_clk, input, 1, the only clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester byte valid.
REQ-005 The block SHALL have ports req0_data / req1_data, input, 8 each, requester byte.
REQ-006 The block SHALL have ports req0_last / req1_last, input, 1 each, marking the final byte of a frame.
REQ-007 The block SHALL have ports req0_err / req1_err, input, 1 each, requester frame error flag.
REQ-008 The block SHALL have ports req0_ready / req1_ready, output, 1 each, byte accepted when ready and valid are both high.
REQ-009 The block SHALL have ports tx_mac_valid, tx_mac_data[7:0], tx_mac_last and tx_mac_error, outputs, 1/8/1/1, the MAC TX stream.
REQ-010 The block SHALL have port tx_mac_ready, input, 1, MAC accepts the byte this cycle.
REQ-011 The block SHALL have port tx_collision, input, 1, MAC collision indication.
REQ-012 The block SHALL have port grant, output, 2, one-hot owner of the MAC: bit0 is req0, bit1 is req1, 00 means none.
REQ-013 The block SHALL have ports frame_cnt0 / frame_cnt1, output, 16 each, count of frames completed per requester.
REQ-014 The block SHALL have port coll_cnt, output, 16, count of collision cycles seen while granted.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, GRANT0, GRANT1 and GAP.
REQ-016 In IDLE, the block SHALL go to GRANT0 if only req0_valid is high, and to GRANT1 if only req1_valid is high.
REQ-017 In IDLE with both valids high, the block SHALL grant the requester that is not last_grant (round robin).
REQ-018 last_grant SHALL be a 1-bit register updated on entry to GRANTx.
REQ-019 Grant latency SHALL be one cycle: valid seen in IDLE at cycle n puts the FSM in GRANTx and drives tx_mac_valid at n+1.
REQ-020 In GRANTx, tx_mac_valid/data/last/error SHALL combinationally follow reqx_valid/data/last/err, with zero added latency.
REQ-021 In GRANTx, reqx_ready SHALL equal tx_mac_ready.
REQ-022 The non-granted ready and all readys outside GRANTx SHALL be 0.
REQ-023 Outside GRANTx, tx_mac_valid, tx_mac_last and tx_mac_error SHALL be 0 and tx_mac_data SHALL be 8'h00.
REQ-024 grant SHALL be 01 in GRANT0, 10 in GRANT1, and 00 otherwise.
REQ-025 Frames SHALL be atomic: no re-arbitration occurs until a handshake with reqx_last=1.
REQ-026 A handshake with last=1 SHALL increment frame_cntx, saturating at 16'hFFFF.
REQ-027 On that last-byte handshake, the FSM SHALL go to GAP with gap counter loaded with GAP_CYCLES-1, or go straight to IDLE when GAP_CYCLES=0.
REQ-028 In GAP, the block SHALL decrement the gap counter each cycle and go to IDLE after the cycle in which it reads 0, giving exactly GAP_CYCLES cycles in GAP.
REQ-029 Requests arriving during GAP SHALL be held off (ready=0) and arbitrated in the following IDLE.
REQ-030 A valid that deasserts mid-frame in GRANTx SHALL keep the grant; the FSM waits without a timeout.
REQ-031 tx_collision=1 in GRANT0 or GRANT1 SHALL increment coll_cnt, saturating at 16'hFFFF, with no state change.
REQ-032 tx_collision outside GRANTx SHALL be ignored.
REQ-033 A single-byte frame (valid and last on the first beat) SHALL be legal and handled as in REQ-026..REQ-028.

Reset
REQ-034 On reset=1 at a clock edge, the block SHALL set state to IDLE, last_grant to 1 (req0 wins the first tie), gap counter, frame_cnt0, frame_cnt1 and coll_cnt to 0, and grant to 00.
REQ-035 Reset SHALL override all other inputs and take priority mid-frame; the frame in progress is truncated with no last sent, and no counter increments in that cycle.
REQ-036 All outputs SHALL be at their REQ-023 idle values during reset.

Verification
REQ-037 Reset, then req0 sends a 4-byte frame (tx_mac_ready=1): grant=01 one cycle after valid; bytes pass unchanged; frame_cnt0=1; then 12 GAP cycles with ready=0 before IDLE.
REQ-038 Both requesters continuously valid with 2-byte frames: grants alternate 01,10,01,10 starting with 01; frame_cnt0=frame_cnt1=2 after four frames.
REQ-039 tx_mac_ready toggling 1,0,1,0 during a req1 frame: req1_ready mirrors it, no bytes are lost or duplicated, and req0_ready stays 0 throughout.
REQ-040 GAP_CYCLES=0 with back-to-back single-byte frames from req0: cycle pattern is GRANT0, IDLE, GRANT0, ...; frame_cnt0 increments each frame.
REQ-041 Reset asserted on the third byte of a req0 frame: next cycle state is IDLE, grant=00, counters=0; a subsequent tie then grants req0.
REQ-042 tx_collision pulsed 3 cycles in GRANT1 and 2 cycles in IDLE: coll_cnt=3 and the frame completes normally.
